// File: rtl/switch_debounce_pio.sv
// Purpose : Avalon-MM switch input port; sync + debounce per bit, sticky edge capture, maskable level irq.
// Latency : sw -> sw_clean/edgecap/irq on edge k+1+DEBOUNCE_CYCLES; readdata valid the cycle after read.
// Backpr. : none; every read/write completes in one cycle, no waitrequest.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   sw               raw switch pins (asynchronous to clk)
//   address/read/write/writedata/readdata   Avalon-MM slave, read latency 1
//   irq              level interrupt, |(edgecap & irqmask)
//   sw_clean         debounced switch state
//
// Register map (word addresses), compatible with the stock input PIO:
//   0 DATA (RO)  1 DIRECTION (RO, 0)  2 IRQMASK (RW)  3 EDGECAP (W1C)

module switch_debounce_pio #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [WIDTH-1:0] sw_clean
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      rd_mux;

    // Only the low WIDTH bits of writedata are meaningful; fold the rest so
    // the full bus is visibly consumed.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Two-flop synchronizer, nothing between the stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: any cycle where sync2 agrees with stable restarts the
    // count, so only a run of DEBOUNCE_CYCLES disagreeing cycles is accepted.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i] + 1'b1;
            if (sync2[i] == stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                stable_nxt[i] = sync2[i];
                cnt_nxt[i]    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // W1C clear mask for this cycle.
    always_comb begin
        edge_clr = '0;
        if (write && (address == ADDR_EDGECAP)) begin
            edge_clr = writedata[WIDTH-1:0];
        end
    end

    // New edges are OR-ed in after the clear, so a same-edge set beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecap <= '0;
            irqmask <= '0;
        end else begin
            edgecap <= (edgecap & ~edge_clr) | (stable ^ stable_nxt);
            if (write && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Read mux samples pre-write register values, so a simultaneous
    // read+write returns the old contents.
    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_DIR:     rd_mux            = '0;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
            default:      rd_mux            = '0;
        endcase
    end

    // readdata holds until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end
    end

    assign irq      = |(edgecap & irqmask);
    assign sw_clean = stable;

endmodule

// File: tb/tb_switch_debounce_pio.sv
// Directed bench for switch_debounce_pio with WIDTH=2, DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. after the edge has settled and well before the next one.

module tb_switch_debounce_pio;

    localparam int WIDTH = 2;
    localparam int DC    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] sw;
    logic [1:0]       address;
    logic             read;
    logic             write;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic             irq;
    logic [WIDTH-1:0] sw_clean;

    int n_vec = 0;
    int n_err = 0;

    switch_debounce_pio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .sw_clean  (sw_clean)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    logic [31:0] rd;

    initial begin
        reset     = 1'b1;
        sw        = 2'b00;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;

        // ---------------- reset ----------------
        #1;
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_sw_clean", {30'd0, sw_clean}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            chk($sformatf("rst_read_a%0d", a), rd, 32'd0);
        end
        chk("rst_irq_after", {31'd0, irq}, 32'd0);
        chk("rst_sw_clean_after", {30'd0, sw_clean}, 32'd0);

        // read-only / masked-width register behaviour
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, rd);
        chk("data_ro", rd, 32'd0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, rd);
        chk("dir_ro", rd, 32'd0);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, rd);
        chk("irqmask_width", rd, 32'd3);

        // ---------------- clean rising edge on sw[0] ----------------
        bus_write(2'd2, 32'd1);
        sw = 2'b01;                     // before edge k
        repeat (5) tick();              // edges k..k+4
        chk("rise_not_yet", {30'd0, sw_clean}, 32'd0);
        chk("rise_irq_not_yet", {31'd0, irq}, 32'd0);
        tick();                         // edge k+5
        chk("rise_sw_clean", {30'd0, sw_clean}, 32'd1);
        chk("rise_irq", {31'd0, irq}, 32'd1);
        bus_read(2'd3, rd);
        chk("rise_edgecap", rd, 32'd1);
        bus_read(2'd0, rd);
        chk("rise_data", rd, 32'd1);
        bus_write(2'd3, 32'd1);
        chk("w1c_irq_drop", {31'd0, irq}, 32'd0);
        bus_read(2'd3, rd);
        chk("w1c_edgecap", rd, 32'd0);

        // ---------------- glitch rejection on sw[1] ----------------
        sw = 2'b11;
        repeat (3) tick();
        sw = 2'b01;
        repeat (8) tick();
        chk("glitch_sw_clean", {30'd0, sw_clean}, 32'd1);
        bus_read(2'd3, rd);
        chk("glitch_edgecap", rd, 32'd0);
        sw = 2'b11;
        repeat (6) tick();
        chk("hold_sw_clean", {30'd0, sw_clean}, 32'd3);
        chk("hold_irq_masked", {31'd0, irq}, 32'd0);
        bus_read(2'd3, rd);
        chk("hold_edgecap", rd, 32'd2);

        // ---------------- falling edge on sw[0] ----------------
        bus_write(2'd3, 32'd3);
        bus_read(2'd3, rd);
        chk("fall_clear", rd, 32'd0);
        sw = 2'b10;
        repeat (5) tick();
        chk("fall_not_yet", {30'd0, sw_clean}, 32'd3);
        tick();
        chk("fall_sw_clean", {30'd0, sw_clean}, 32'd2);
        chk("fall_irq", {31'd0, irq}, 32'd1);
        bus_read(2'd3, rd);
        chk("fall_edgecap", rd, 32'd1);
        bus_read(2'd0, rd);
        chk("fall_data", rd, 32'd2);

        // ---------------- set/clear collision ----------------
        bus_write(2'd3, 32'd3);
        chk("coll_pre_irq", {31'd0, irq}, 32'd0);
        sw = 2'b11;
        repeat (5) tick();              // edges k..k+4
        bus_write(2'd3, 32'd1);         // edge k+5: stable[0] changes here
        chk("coll_sw_clean", {30'd0, sw_clean}, 32'd3);
        chk("coll_irq", {31'd0, irq}, 32'd1);
        bus_read(2'd3, rd);
        chk("coll_edgecap", rd, 32'd1);

        // ---------------- reset mid-debounce ----------------
        reset = 1'b1;
        sw    = 2'b00;
        tick();
        reset = 1'b0;
        tick();
        sw = 2'b01;
        repeat (4) tick();              // cnt[0] == 2 now
        reset = 1'b1;
        #1;
        chk("mid_rst_sw_clean", {30'd0, sw_clean}, 32'd0);
        chk("mid_rst_readdata", readdata, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("mid_rst_not_early", {30'd0, sw_clean}, 32'd0);
        tick();
        chk("mid_rst_accept", {30'd0, sw_clean}, 32'd1);
        bus_read(2'd3, rd);
        chk("mid_rst_edgecap", rd, 32'd1);
        chk("mid_rst_irq_mask0", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/switch_debounce_pio.md
# switch_debounce_pio

Avalon-MM slave peripheral that carries the dev-kit slide switches into the Nios II system. It synchronizes and debounces each switch bit, latches any change in a sticky edge-capture register, and raises a maskable interrupt. It is instantiated in the top level between the `SW` pins and the Qsys system, replacing the stock switch PIO on the input path; its register map matches that PIO so existing software is unchanged.

## Interface
- `WIDTH`, default 2: number of switch bits, 1..32.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a switch change (10 ms at 50 MHz); must be at least 2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk`  in  1  system clock, driven from `MAX10_CLK1_50`.
- `reset`  in  1  asynchronous, active-high reset.
- `sw`  in  WIDTH  raw switch pins, asynchronous to `clk`.
- `address`  in  2  Avalon word address.
- `read`  in  1  Avalon read strobe.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  Avalon read data, fixed read latency 1.
- `irq`  out  1  level interrupt to Nios.
- `sw_clean`  out  WIDTH  debounced switch state, for direct fabric use such as LED mirroring.

## Operation
- **Synchronizer:** two flops per bit, `sync1` and then `sync2`; no logic sits between them.
- **Debounce, per bit, independent counter `cnt`:**
  - if `sync2 == stable`, `cnt` is set to 0;
  - otherwise, if `cnt == DEBOUNCE_CYCLES-1`, `stable` takes `sync2` and `cnt` is set to 0;
  - otherwise `cnt` increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync2` never reaches `stable`.
- **Edge capture:** bit i of `edgecap` is set on the same clock edge on which `stable[i]` changes, for both rising and falling changes. The bit is sticky.
- **Register map** (word addresses):
  - **0 DATA (RO):** `stable` zero-extended to 32 bits. Writes are ignored.
  - **1 DIRECTION (RO):** reads 0. Writes are ignored.
  - **2 IRQMASK (RW):** low WIDTH bits are stored; upper bits read 0.
  - **3 EDGECAP (W1C):** writing a 1 to bit i clears `edgecap[i]`. Reads return `edgecap`.
- **Set/clear collision:** if a W1C write and a new edge hit the same bit on the same edge, the set wins and the bit stays 1.
- **Interrupt:** `irq = |(edgecap & irqmask)`, combinational from registers only.
- **Write/read overlap:** `read` and `write` asserted together is not expected. If it happens, the write takes effect and `readdata` returns the pre-write value.
- `sw_clean = stable`.

## Timing
- **Reset values** (asynchronous, while `reset` = 1): `sync1`, `sync2`, `stable`, `cnt`, `edgecap`, `irqmask` and `readdata` are all 0. Therefore `irq` = 0 and `sw_clean` = 0.
- **Power-up:** a switch that is already high at reset release produces one accepted 0→1 change after `DEBOUNCE_CYCLES` + 2 cycles. That change sets its `edgecap` bit, which is intended.
- **Input latency:** if `sw` changes and holds before clock edge k, `sync2` shows the change after edge k+1 and `stable`/`sw_clean` update on edge k+1+`DEBOUNCE_CYCLES`. `edgecap` sets on that same edge, and `irq` rises in that same cycle if the bit is masked in.
- **Reads:** `readdata` is registered on the edge where `read` = 1 and is valid in the following cycle. It holds its value until the next read.
- **Writes:** registers update on the edge where `write` = 1. A W1C clear drops `irq` in the next cycle unless other masked bits remain set.
- **No wait states:** `read` and `write` complete in one cycle; there is no waitrequest.
- **Reset mid-debounce:** the counter and `stable` return to 0 immediately, and a pending change restarts from zero count after release.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES` = 4 and `WIDTH` = 2.

- **Reset:** hold `reset` 3 cycles with `sw` = 2'b00, then release; read addresses 0–3 → each returns 0, `irq` = 0, `sw_clean` = 0.
- **Clean edge:** set `irqmask` = 2'b01 and drive `sw[0]` high before edge k → `sw_clean` = 2'b01 on edge k+5 and `irq` = 1 the same cycle. Read of address 3 returns 1; write 1 to address 3 → `irq` = 0 next cycle.
- **Glitch rejection:** pulse `sw[1]` high for 3 cycles → `sw_clean[1]` stays 0 and `edgecap` stays 0. Then hold high for 6 cycles → accepted, and `edgecap[1]` = 1 with `irq` = 0 because bit 1 is masked out.
- **Falling edge:** hold `sw[0]` high until accepted, clear `edgecap`, then drop `sw[0]` → `edgecap[0]` sets again after 5 cycles and DATA reads 0.
- **Collision:** issue a W1C write to bit 0 on the same edge that `stable[0]` changes → `edgecap[0]` remains 1.
- **Reset mid-operation:** assert `reset` when `cnt[0]` = 2, then release with `sw[0]` still high → `stable[0]` updates exactly 2 + 4 cycles after release, not earlier.
